// File: rtl/prefetch_unit.sv
// Instruction prefetch: issues word-aligned sequential fetches after a PC set,
// buffers responses in a small FIFO and squashes stale responses on redirect.
module prefetch_unit #(
  parameter int FifoDepth = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        err_o,
  output logic        busy_o
);
  localparam int CW = $clog2(FifoDepth + 1);
  localparam int PW = $clog2(FifoDepth);
  localparam logic [CW:0]   DEPTH = (CW + 1)'(FifoDepth);
  localparam logic [PW-1:0] LAST  = PW'(FifoDepth - 1);

  typedef enum logic {IDLE, WAIT_GNT} state_e;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } entry_t;

  state_e        state_q, state_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d, hold_addr_q, hold_addr_d;
  logic [31:0]   branch_addr_q, branch_addr_d;
  logic          branch_pend_q, branch_pend_d, err_stop_q, err_stop_d;
  logic [CW-1:0] outst_q, outst_d, discard_q, discard_d, cnt_q, cnt_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, aq_rd_q, aq_rd_d, aq_wr_q, aq_wr_d;
  entry_t        fifo_q [FifoDepth];
  logic [31:0]   aq_q [FifoDepth];
  logic [31:0]   br_addr;
  logic          credit, gnt, drop, push, pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    br_addr = {addr_i[31:2], 2'b00};
    credit  = req_i && !err_stop_q && (({1'b0, outst_q} + {1'b0, cnt_q}) < DEPTH);
    if (state_q == WAIT_GNT) begin
      instr_req_o  = 1'b1;
      instr_addr_o = hold_addr_q;
    end else begin
      instr_req_o  = credit;
      instr_addr_o = branch_i ? br_addr : fetch_addr_q;
    end
    gnt     = instr_req_o && instr_gnt_i;
    drop    = instr_rvalid_i && (discard_q != '0);
    push    = instr_rvalid_i && !drop && !branch_i;
    valid_o = (cnt_q != '0) && !branch_i;
    pop     = valid_o && ready_i;
  end

  always_comb begin
    state_d       = state_q;
    fetch_addr_d  = fetch_addr_q;
    hold_addr_d   = hold_addr_q;
    branch_addr_d = branch_addr_q;
    branch_pend_d = branch_pend_q;
    outst_d       = outst_q + CW'(gnt) - CW'(instr_rvalid_i);
    case (state_q)
      IDLE: begin
        if (instr_req_o) begin
          if (gnt) begin
            fetch_addr_d = instr_addr_o + 32'd4;
          end else begin
            state_d     = WAIT_GNT;
            hold_addr_d = instr_addr_o;
          end
        end else if (branch_i) begin
          fetch_addr_d = br_addr;
        end
      end
      default: begin
        if (gnt) begin
          state_d      = IDLE;
          fetch_addr_d = hold_addr_q + 32'd4;
          if (branch_i) begin
            fetch_addr_d  = br_addr;
            branch_pend_d = 1'b0;
          end else if (branch_pend_q) begin
            fetch_addr_d  = branch_addr_q;
            branch_pend_d = 1'b0;
          end
        end else if (branch_i) begin
          branch_pend_d = 1'b1;
          branch_addr_d = br_addr;
        end
      end
    endcase

    // A request granted in IDLE during a branch already targets the new address.
    if (branch_i) begin
      discard_d = outst_d - CW'(gnt && state_q == IDLE);
    end else begin
      discard_d = discard_q - CW'(drop) + CW'(gnt && branch_pend_q);
    end

    rd_d       = rd_q;
    wr_d       = wr_q;
    err_stop_d = err_stop_q;
    if (branch_i) begin
      cnt_d      = '0;
      rd_d       = '0;
      wr_d       = '0;
      err_stop_d = 1'b0;
    end else begin
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      if (push) wr_d = inc(wr_q);
      if (pop) rd_d = inc(rd_q);
      if (push && instr_err_i) err_stop_d = 1'b1;
    end
    aq_wr_d = gnt ? inc(aq_wr_q) : aq_wr_q;
    aq_rd_d = instr_rvalid_i ? inc(aq_rd_q) : aq_rd_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      fetch_addr_q  <= '0;
      hold_addr_q   <= '0;
      branch_addr_q <= '0;
      branch_pend_q <= 1'b0;
      err_stop_q    <= 1'b0;
      outst_q       <= '0;
      discard_q     <= '0;
      cnt_q         <= '0;
      rd_q          <= '0;
      wr_q          <= '0;
      aq_rd_q       <= '0;
      aq_wr_q       <= '0;
      for (int i = 0; i < FifoDepth; i++) begin
        fifo_q[i] <= '0;
        aq_q[i]   <= '0;
      end
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      hold_addr_q   <= hold_addr_d;
      branch_addr_q <= branch_addr_d;
      branch_pend_q <= branch_pend_d;
      err_stop_q    <= err_stop_d;
      outst_q       <= outst_d;
      discard_q     <= discard_d;
      cnt_q         <= cnt_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      aq_rd_q       <= aq_rd_d;
      aq_wr_q       <= aq_wr_d;
      if (push) fifo_q[wr_q] <= '{aq_q[aq_rd_q], instr_rdata_i, instr_err_i};
      if (gnt) aq_q[aq_wr_q] <= instr_addr_o;
    end
  end

  assign rdata_o = fifo_q[rd_q].data;
  assign addr_o  = fifo_q[rd_q].addr;
  assign err_o   = fifo_q[rd_q].err;
  assign busy_o  = (state_q == WAIT_GNT) || (outst_q != '0);
endmodule
